// File: rtl/prince_ti_pkg.sv
// Shared types, stage constants and nibble helpers for the threshold-implemented PRINCE S-box layer.
// Optional build macro used by this slice: SHARE_REFRESH_EN.
package prince_ti_pkg;

    localparam int SHARES     = 3;
    localparam int STATE_W    = 64;
    localparam int NIBBLES    = STATE_W / 4;
    localparam int MAX_STAGES = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    // Row r of a matrix selects the input bits XORed into output bit r; identity until the cipher team supplies the decomposition.
    localparam logic [MAX_STAGES-1:0][3:0][3:0] AFFINE_MAT   = {MAX_STAGES{16'h8421}};
    localparam logic [MAX_STAGES-1:0][3:0]      AFFINE_CONST = {MAX_STAGES{4'h0}};

    function automatic logic [3:0] affine_nibble(input logic [3:0][3:0] mat, input logic [3:0] x);
        logic [3:0] y;
        for (int r = 0; r < 4; r++) begin
            y[r] = ^(mat[r] & x);
        end
        return y;
    endfunction

    // Output share i of Q294 from input shares i (yi) and i+1 (yj) only.
    function automatic logic [3:0] q294_share(input logic [3:0] yi, input logic [3:0] yj);
        logic [3:0] z;
        z[3] = yi[3];
        z[2] = yi[2];
        z[1] = yi[1] ^ (yi[3] & yi[2]) ^ (yi[3] & yj[2]) ^ (yj[3] & yi[2]);
        z[0] = yi[0] ^ (yi[3] & yi[1]) ^ (yi[3] & yj[1]) ^ (yj[3] & yi[1]);
        return z;
    endfunction

endpackage

// File: rtl/prince_tisbox_seq_q294.sv
// Combinational 3-share Q294 on one nibble; each output share sees only two input shares.
module q294_ti_nibble
    import prince_ti_pkg::*;
(
    input  logic [3:0] x0,
    input  logic [3:0] x1,
    input  logic [3:0] x2,
    output logic [3:0] z0,
    output logic [3:0] z1,
    output logic [3:0] z2
);

    assign z0 = q294_share(x0, x1);
    assign z1 = q294_share(x1, x2);
    assign z2 = q294_share(x2, x0);

endmodule

// File: rtl/prince_tisbox_seq.sv
// Start/busy/done sequencer running NUM_STAGES shared quadratic stages over a 3-share 64-bit state.
// Optional build macro: SHARE_REFRESH_EN adds rnd_i and refreshes the shares in every RUN cycle.
module prince_tisbox_seq
    import prince_ti_pkg::*;
#(
    parameter int NUM_STAGES = 3
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [SHARES*STATE_W-1:0]    state_i,
`ifdef SHARE_REFRESH_EN
    input  logic [2*STATE_W-1:0]         rnd_i,
`endif
    output logic                         ready_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [SHARES*STATE_W-1:0]    state_o
);

    localparam int                CNT_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_STAGES - 1);

    fsm_state_e                   fsm_r, fsm_s;
    logic [CNT_W-1:0]             stage_cnt_r, stage_cnt_s;
    logic [SHARES*STATE_W-1:0]    state_r, state_s, stage_s;
    logic                         ready_r, busy_r, done_r;
    logic                         ready_s, busy_s, done_s;
    logic [STATE_W-1:0]           sh0_s, sh1_s, sh2_s;
    logic [3:0][3:0]              mat_s;
    logic [3:0]                   cst_s;

    // Share refresh ahead of the stage (pass-through when the refresh build is off).
    always_comb begin
`ifdef SHARE_REFRESH_EN
        sh0_s = state_r[STATE_W-1:0]           ^ rnd_i[STATE_W-1:0];
        sh1_s = state_r[2*STATE_W-1:STATE_W]   ^ rnd_i[2*STATE_W-1:STATE_W];
        sh2_s = state_r[3*STATE_W-1:2*STATE_W] ^ rnd_i[STATE_W-1:0] ^ rnd_i[2*STATE_W-1:STATE_W];
`else
        sh0_s = state_r[STATE_W-1:0];
        sh1_s = state_r[2*STATE_W-1:STATE_W];
        sh2_s = state_r[3*STATE_W-1:2*STATE_W];
`endif
    end

    // Select the affine map of the stage currently being applied.
    always_comb begin
        mat_s = AFFINE_MAT[stage_cnt_r];
        cst_s = AFFINE_CONST[stage_cnt_r];
    end

    for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
        logic [3:0] y0_s, y1_s, y2_s;

        // The constant lands on share 0 only so the unshared value gets it exactly once.
        assign y0_s = affine_nibble(mat_s, sh0_s[4*n +: 4]) ^ cst_s;
        assign y1_s = affine_nibble(mat_s, sh1_s[4*n +: 4]);
        assign y2_s = affine_nibble(mat_s, sh2_s[4*n +: 4]);

        q294_ti_nibble u_q294 (
            .x0 (y0_s),
            .x1 (y1_s),
            .x2 (y2_s),
            .z0 (stage_s[4*n +: 4]),
            .z1 (stage_s[STATE_W + 4*n +: 4]),
            .z2 (stage_s[2*STATE_W + 4*n +: 4])
        );
    end

    // Next-state, counter and datapath selection; handshake flags follow the next state so they leave a register.
    always_comb begin
        fsm_s       = fsm_r;
        stage_cnt_s = stage_cnt_r;
        state_s     = state_r;
        case (fsm_r)
            ST_IDLE: begin
                if (start_i) begin
                    fsm_s = ST_LOAD;
                end else begin
                    fsm_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                fsm_s       = ST_RUN;
                state_s     = state_i;
                stage_cnt_s = '0;
            end
            ST_RUN: begin
                state_s = stage_s;
                if (stage_cnt_r == LAST_CNT) begin
                    fsm_s = ST_DONE;
                end else begin
                    fsm_s       = ST_RUN;
                    stage_cnt_s = stage_cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                fsm_s = ST_IDLE;
            end
            default: begin
                fsm_s = ST_IDLE;
            end
        endcase
        ready_s = (fsm_s == ST_IDLE);
        busy_s  = (fsm_s == ST_LOAD) || (fsm_s == ST_RUN);
        done_s  = (fsm_s == ST_DONE);
    end

    // State, counter, data and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r       <= ST_IDLE;
            stage_cnt_r <= '0;
            state_r     <= '0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_s;
            stage_cnt_r <= stage_cnt_s;
            state_r     <= state_s;
            ready_r     <= ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign ready_o = ready_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign state_o = state_r;

endmodule

// File: tb/tb_prince_tisbox_seq.sv
// Bench for prince_tisbox_seq: NUM_STAGES=1 and 2 instances, vector table, scoreboard and handshake/reset sequences.
module tb_prince_tisbox_seq;

    logic           clk = 1'b0;
    logic           rst;
    logic           start1, start2;
    logic [191:0]   st1, st2, so1, so2;
    logic           ready1, busy1, done1, ready2, busy2, done2;
`ifdef SHARE_REFRESH_EN
    logic [127:0]   rnd;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { logic [63:0] v; int due; } exp_t;
    typedef struct { logic [63:0] v, s1, s2, e1, e2; } vec_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [63:0] nx1 = 64'h0, nx2 = 64'h0;
    vec_t        tbl[5];

    always #5 clk = ~clk;

    prince_tisbox_seq #(.NUM_STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .state_i(st1),
`ifdef SHARE_REFRESH_EN
        .rnd_i(rnd),
`endif
        .ready_o(ready1), .busy_o(busy1), .done_o(done1), .state_o(so1)
    );

    prince_tisbox_seq #(.NUM_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .state_i(st2),
`ifdef SHARE_REFRESH_EN
        .rnd_i(rnd),
`endif
        .ready_o(ready2), .busy_o(busy2), .done_o(done2), .state_o(so2)
    );

`ifdef SHARE_REFRESH_EN
    always @(negedge clk) rnd = {$urandom, $urandom, $urandom, $urandom};
`endif

    function automatic logic [63:0] xor3(input logic [191:0] s);
        return s[63:0] ^ s[127:64] ^ s[191:128];
    endfunction

    // Reference Q on one nibble as a lookup: A<->B, C->E->D->F->C, others fixed.
    function automatic logic [3:0] q_nib(input logic [3:0] x);
        case (x)
            4'hA: return 4'hB;
            4'hB: return 4'hA;
            4'hC: return 4'hE;
            4'hD: return 4'hF;
            4'hE: return 4'hD;
            4'hF: return 4'hC;
            default: return x;
        endcase
    endfunction

    function automatic logic [63:0] qn(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = v;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 16; b++) r[4*b +: 4] = q_nib(r[4*b +: 4]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Accept tracking: a start seen with ready high at an edge schedules one result.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            if (start1 && ready1) q1.push_back('{nx1, cyc + 2});
            if (start2 && ready2) q2.push_back('{nx2, cyc + 3});
        end
    end

    // Scoreboard: every done pulse must match the oldest pending result in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++; $display("FAIL d1_unexpected_done cyc=%0d", cyc);
            end else begin
                e = q1.pop_front();
                if (cyc != e.due || xor3(so1) !== e.v) begin
                    errors++;
                    $display("FAIL d1_result cyc=%0d due=%0d got=%h exp=%h", cyc, e.due, xor3(so1), e.v);
                end
            end
        end else if (q1.size() != 0 && cyc > q1[0].due) begin
            checks++; errors++;
            $display("FAIL d1_timeout due=%0d got=no_done", q1[0].due);
            void'(q1.pop_front());
        end
        if (done2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++; $display("FAIL d2_unexpected_done cyc=%0d", cyc);
            end else begin
                e = q2.pop_front();
                if (cyc != e.due || xor3(so2) !== e.v) begin
                    errors++;
                    $display("FAIL d2_result cyc=%0d due=%0d got=%h exp=%h", cyc, e.due, xor3(so2), e.v);
                end
            end
        end else if (q2.size() != 0 && cyc > q2[0].due) begin
            checks++; errors++;
            $display("FAIL d2_timeout due=%0d got=no_done", q2[0].due);
            void'(q2.pop_front());
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && (q1.size() != 0 || q2.size() != 0); k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_both(input logic [63:0] v, s1, s2, e1, e2);
        @(negedge clk);
        st1 = {s2, s1, v ^ s1 ^ s2};
        st2 = {s1, v ^ s1 ^ s2, s2};
        nx1 = e1; nx2 = e2;
        start1 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        @(negedge clk);
        st1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        st2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        drain();
    endtask

    initial begin
        int nd, last;
        logic [63:0] v, s1, s2;
        logic [2:0]  phase[5];

        tbl[0] = '{64'hEEEE_EEEE_EEEE_EEEE, 64'h0, 64'h0, 64'hDDDD_DDDD_DDDD_DDDD, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[1] = '{64'hEEEE_EEEE_EEEE_EEEE, 64'h1357_9BDF_2468_ACE0, 64'hC0FF_EE12_3456_789A,
                   64'hDDDD_DDDD_DDDD_DDDD, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2] = '{64'h0123_4567_89AB_CDEF, 64'hA5A5_5A5A_0F0F_F0F0, 64'h3C3C_C3C3_9696_6969,
                   64'h0123_4567_89BA_EFDC, 64'h0123_4567_89AB_DCFE};
        tbl[3] = '{64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_0BAD_F00D, 64'h1122_3344_5566_7788,
                   64'hCDFE_AB98_7654_3210, 64'hEFCD_BA98_7654_3210};
        tbl[4] = '{64'hAAAA_5555_CCCC_0000, 64'h8BAD_F00D_CAFE_BABE, 64'h0000_FFFF_1234_8765,
                   64'hBBBB_5555_EEEE_0000, 64'hAAAA_5555_DDDD_0000};

        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; st1 = '0; st2 = '0;
`ifdef SHARE_REFRESH_EN
        rnd = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready1", ready1, 1); chk("rst_busy1", busy1, 0);
        chk("rst_done1",  done1,  0); chk("rst_state1", xor3(so1) | so1[63:0], 0);
        chk("rst_ready2", ready2, 1); chk("rst_busy2", busy2, 0);
        chk("rst_done2",  done2,  0); chk("rst_state2", so2[191:128] | so2[127:64] | so2[63:0], 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_both(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].e1, tbl[i].e2);

        for (int i = 0; i < 4; i++) begin
            v  = {$urandom, $urandom};
            s1 = {$urandom, $urandom};
            s2 = {$urandom, $urandom};
            run_both(v, s1, s2, qn(v, 1), qn(v, 2));
        end

        // Handshake phases of a single two-stage run: {ready, busy, done}.
        phase[0] = 3'b010; phase[1] = 3'b010; phase[2] = 3'b010; phase[3] = 3'b001; phase[4] = 3'b100;
        @(negedge clk);
        st2 = {64'h0, 64'h0, 64'hCCCC_CCCC_CCCC_CCCC}; nx2 = 64'hDDDD_DDDD_DDDD_DDDD; start2 = 1'b1;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (p == 1) st2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            chk($sformatf("phase%0d", p), {ready2, busy2, done2}, phase[p]);
        end
        drain();

        // start pulses during RUN and DONE are ignored.
        @(negedge clk);
        st2 = {64'h0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA}; nx2 = 64'hAAAA_AAAA_AAAA_AAAA; start2 = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start2 = (k == 1 || k == 3);
            if (done2) nd++;
        end
        start2 = 1'b0;
        chk("ignore_runs", nd, 1);
        drain();

        // Held start gives a done every four cycles on the single-stage instance.
        @(negedge clk);
        st1 = {64'h0, 64'h0, 64'hEEEE_EEEE_EEEE_EEEE}; nx1 = 64'hDDDD_DDDD_DDDD_DDDD; start1 = 1'b1;
        nd = 0; last = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 15) start1 = 1'b0;
            if (done1) begin
                if (last >= 0) chk("hold_period", cyc - last, 4);
                last = cyc; nd++;
            end
        end
        start1 = 1'b0;
        chk("hold_runs", nd, 4);
        drain();

        // Reset in the second RUN cycle discards the run.
        @(negedge clk);
        st2 = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; nx2 = 64'hEEEE_EEEE_EEEE_EEEE; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst_ready", ready2, 1); chk("mid_rst_busy", busy2, 0);
        chk("mid_rst_done", done2, 0);
        chk("mid_rst_state", so2[191:128] | so2[127:64] | so2[63:0], 0);
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done2) nd++;
        end
        chk("mid_rst_nodone", nd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/prince_tisbox_seq.md
# prince_tisbox_seq

Sequencer for one 3-share threshold-implemented PRINCE S-box layer over a 64-bit state. It applies a chain of NUM_STAGES quadratic stages to all 16 nibbles in parallel, one stage per clock, with a register between stages. Each stage is a per-nibble affine map followed by the shared Q294 quadratic function. It sits between the round-key/linear-layer logic and the next round, and owns the start/busy/done handshake for the S-box phase.

## Interface
- NUM_STAGES, default 3: number of quadratic stages per S-box evaluation; legal range 1..7.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start_i  in  1: request; sampled only in IDLE.
- state_i  in  192: input shares; [63:0] share 0, [127:64] share 1, [191:128] share 2; nibble n is bits [4n+3:4n] of each share.
- ready_o  out  1: high in IDLE; start_i is accepted only when ready_o is high.
- busy_o  out  1: high in LOAD/RUN.
- done_o  out  1: one-cycle pulse; state_o is valid in that cycle.
- state_o  out  192: shared result, driven directly from the state register; same share layout as state_i.
- rnd_i  in  128: fresh randomness, present only with SHARE_REFRESH_EN; [63:0] r0, [127:64] r1.

## Operation
- FSM states and transitions:
  - IDLE → LOAD on start_i.
  - LOAD → RUN unconditionally.
  - RUN → RUN while stage_cnt < NUM_STAGES-1.
  - RUN → DONE when stage_cnt == NUM_STAGES-1.
  - DONE → IDLE unconditionally.
- LOAD: the state register captures state_i, and stage_cnt is cleared to 0.
- RUN: the state register captures STAGE(stage_cnt, state), then stage_cnt increments.
- STAGE(k):
  - For every nibble of every share, compute y_i = A_k·x_i.
  - Add constant c_k to share 0 only.
  - Apply the shared quadratic per nibble. For output share i, with j = (i+1) mod 3:
    - out3 = y_i3
    - out2 = y_i2
    - out1 = y_i1 ^ y_i3·y_i2 ^ y_i3·y_j2 ^ y_j3·y_i2
    - out0 = y_i0 ^ y_i3·y_i1 ^ y_i3·y_j1 ^ y_j3·y_i1
  - XOR of the three output shares = Q(y) = (y3, y2, y1^y3y2, y0^y3y1).
  - Each output share depends only on input shares i and i+1 (non-completeness). The stage register is mandatory and no combinational path may span two stages.
- DONE: the state register holds. state_o equals the final result from this cycle onward.
- Boundary behaviour:
  - start_i outside IDLE is ignored, never queued.
  - start_i held high gives back-to-back runs, with one IDLE cycle between runs.
  - Changes on state_i after LOAD have no effect.
  - rst in any state forces IDLE on the next edge and discards the run in progress.

## Timing
- Reset values:
  - ready_o = 1; busy_o = 0; done_o = 0
  - state_o = 0; stage_cnt = 0; FSM = IDLE
- Start accepted at edge E: LOAD during the next cycle, then NUM_STAGES RUN cycles, then DONE.
- done_o is high in cycle E+NUM_STAGES+2 (counting the cycle after E as E+1). Latency from start to done is NUM_STAGES+2 cycles; throughput is one layer per NUM_STAGES+3 cycles.
- busy_o is high in LOAD and RUN and low in DONE. ready_o is low from LOAD through DONE.
- stage_cnt width is clog2(NUM_STAGES); NUM_STAGES=1 uses a 1-bit counter. The counter never wraps: it leaves RUN at NUM_STAGES-1.

## Configuration
- SHARE_REFRESH_EN defined:
  - The rnd_i port exists.
  - In every RUN cycle, before the stage, shares are refreshed: s0 ^= r0, s1 ^= r1, s2 ^= r0^r1. The unshared value is unchanged.
  - The same rnd_i is used for all 16 nibbles of that cycle.
- SHARE_REFRESH_EN undefined:
  - No rnd_i port; shares pass to each stage unrefreshed.
  - Timing is identical in both builds.

## Structure
- Package prince_ti_pkg holds:
  - SHARES = 3, STATE_W = 64.
  - The FSM state enum.
  - AFFINE_MAT[k] (4x4 bit matrix per stage) and AFFINE_CONST[k] (nibble).
  - The default for all stages is identity matrix and constant 0; the real decomposition constants are filled in by the cipher team.
- Sub-module q294_ti_nibble: combinational, 3 shares × 4 bits in, 3 shares × 4 bits out, implementing the shared quadratic above.
  - The layer instantiates 16 of these in a generate loop.
  - The affine map and the stage multiplexing by stage_cnt stay in the top module.

## Test plan
- Reset check: assert rst for 2 cycles → ready_o=1, busy_o=0, done_o=0, state_o=0.
- Single stage: NUM_STAGES=1, identity affine, share0=0xEEEE_EEEE_EEEE_EEEE, shares 1 and 2 = 0 → done_o at start+3, share0^share1^share2 = 0xDDDD_DDDD_DDDD_DDDD.
- Two stages, random split: NUM_STAGES=2, identity affine, unshared value 0xEEEE_EEEE_EEEE_EEEE split with random shares → XOR of outputs = 0xFFFF_FFFF_FFFF_FFFF, done at start+4.
- Handshake: pulse start_i during RUN and DONE → no second run, done_o pulses exactly once. Hold start_i high → done_o every NUM_STAGES+3 cycles.
- Reset mid-run: assert rst in the second RUN cycle → IDLE next cycle, state_o=0, no done_o.
- Refresh build: with SHARE_REFRESH_EN and random rnd_i, repeat the single-stage and two-stage vectors → same unshared results. Individual shares differ from the non-refresh build when rnd_i≠0.
